// File: rtl/ab_input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ab_input_conditioner_pkg
// Description : Shared definitions for the A/B input conditioner. Holds the
//               debounce FSM state encoding, the default debounce counter
//               width and a helper that decodes the debounced level from a
//               state.
// Revision    : 1.0 - initial release
// ============================================================================
package ab_input_conditioner_pkg;

    // Default debounce counter width: 2^19-1 cycles is about 10.5 ms at 50 MHz.
    localparam int unsigned c_DEBOUNCE_W = 19;

    // Debounce FSM state encoding. All four codes are used, so the level
    // output is the MSB of the state.
    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    // The level is high in ONE and in WAIT0. WAIT0 still reports high
    // because the release has not yet been confirmed as stable.
    function automatic logic state_level(input state_t s);
        return (s == ONE) || (s == WAIT0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ab_input_conditioner_debounce_chan.sv
`default_nettype none
// ============================================================================
// Module      : debounce_chan
// Description : One conditioning channel. It synchronises a raw asynchronous
//               input into clk with two flops, debounces it with a
//               counter-based four-state FSM, and produces a registered
//               level plus a one-cycle rising-edge tick.
// Ports       : clk    - system clock, rising edge
//               reset  - asynchronous, active-high
//               sw_raw - raw asynchronous input
//               level  - debounced level, decoded from registered state
//               tick   - one-cycle pulse on a debounced 0->1 change
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_chan
    import ab_input_conditioner_pkg::*;
#(
    parameter int unsigned N = c_DEBOUNCE_W
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic level,
    output logic tick
);

    localparam logic [N-1:0] c_Q_LOAD = {N{1'b1}};
    localparam logic [N-1:0] c_Q_ONE  = N'(1);

    logic         r_sync1;
    logic         r_sync2;
    logic         w_sw;
    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_q;
    logic [N-1:0] w_q_nxt;
    logic         r_tick;
    logic         w_tick_nxt;

    // Two-flop synchroniser. Only the second flop is used by the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sw = r_sync2;

    // State, counter and tick registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ZERO;
            r_q     <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // Next-state logic. The counter is only meaningful in the WAIT states.
    // The exit fires while q is still 1, so q never wraps in normal use.
    // The tick is registered on the WAIT1->ONE edge so that it lines up with
    // the first high cycle of the level.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_tick_nxt  = 1'b0;
        case (r_state)
            ZERO: begin
                if (w_sw) begin
                    w_state_nxt = WAIT1;
                    w_q_nxt     = c_Q_LOAD;
                end
            end
            WAIT1: begin
                if (!w_sw) begin
                    w_state_nxt = ZERO;
                end else begin
                    w_q_nxt = r_q - c_Q_ONE;
                    if (r_q == c_Q_ONE) begin
                        w_state_nxt = ONE;
                        w_tick_nxt  = 1'b1;
                    end
                end
            end
            ONE: begin
                if (!w_sw) begin
                    w_state_nxt = WAIT0;
                    w_q_nxt     = c_Q_LOAD;
                end
            end
            WAIT0: begin
                if (w_sw) begin
                    w_state_nxt = ONE;
                end else begin
                    w_q_nxt = r_q - c_Q_ONE;
                    if (r_q == c_Q_ONE) begin
                        w_state_nxt = ZERO;
                    end
                end
            end
            default: begin
                w_state_nxt = ZERO;
            end
        endcase
    end

    assign level = state_level(r_state);
    assign tick  = r_tick;

endmodule
`default_nettype wire

// File: rtl/ab_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : ab_input_conditioner
// Description : Conditions the two raw inputs that feed the A/B control FSM.
//               Each channel is synchronised and debounced independently.
//               Both channels have the same latency, so raw edges that occur
//               together reach the outputs on the same clock edge.
// Ports       : clk    - system clock, rising edge
//               reset  - asynchronous, active-high
//               a_raw  - raw input, channel A
//               b_raw  - raw input, channel B
//               a, b   - debounced levels
//               a_tick - one-cycle pulse on a debounced 0->1 change of a
//               b_tick - one-cycle pulse on a debounced 0->1 change of b
// Revision    : 1.0 - initial release
// ============================================================================
module ab_input_conditioner
    import ab_input_conditioner_pkg::*;
#(
    parameter int unsigned N = c_DEBOUNCE_W
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_tick,
    output logic b_tick
);

    debounce_chan #(.N(N)) u_chan_a (
        .clk    (clk),
        .reset  (reset),
        .sw_raw (a_raw),
        .level  (a),
        .tick   (a_tick)
    );

    debounce_chan #(.N(N)) u_chan_b (
        .clk    (clk),
        .reset  (reset),
        .sw_raw (b_raw),
        .level  (b),
        .tick   (b_tick)
    );

endmodule
`default_nettype wire
